// File: rtl/retospect_clockgen_pkg.sv
// Shared definitions for the decay-clock generator: channel mode encodings and
// the per-channel config word width derived from the counter width.
package retospect_clockgen_pkg;

   localparam logic [1:0] MODE_OFF      = 2'b00;
   localparam logic [1:0] MODE_PERIODIC = 2'b01;
   localparam logic [1:0] MODE_ONESHOT  = 2'b10;

   // Config word is a 2-bit mode on top of a CNT_W-bit period field.
   function automatic int cfgWidth(input int cntW);
      return cntW + 2;
   endfunction

endpackage

// File: rtl/retospect_clockgen_ch.sv
// One decay-clock channel: shadow scan segment, committed config, period counter,
// one-shot done flag and the registered tick pulse.
module retospect_clockgen_ch
   import retospect_clockgen_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic shift_en_i,
   input  logic ser_i,
   output logic ser_o,
   input  logic commit_i,
   input  logic clr_i,
   input  logic run_i,
   output logic tick_o
);

   localparam int CFG_W = cfgWidth(CNT_W);

   logic [CFG_W-1:0] shadow_q, shadow_d;
   logic [CFG_W-1:0] active_q, active_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             done_q, done_d;
   logic             tick_q, tick_d;

   logic [1:0]       mode;
   logic [CNT_W-1:0] period;
   logic             counting;

   assign mode     = active_q[CFG_W-1:CNT_W];
   assign period   = active_q[CNT_W-1:0];
   assign counting = (mode == MODE_PERIODIC) || ((mode == MODE_ONESHOT) && !done_q);

   // Shifting freezes the active config and counter; a finished one-shot or an
   // OFF/reserved channel parks its counter at zero.
   always_comb begin
      shadow_d = shadow_q;
      active_d = active_q;
      cnt_d    = cnt_q;
      done_d   = done_q;
      tick_d   = 1'b0;
      if (shift_en_i) begin
         shadow_d = {ser_i, shadow_q[CFG_W-1:1]};
      end else if (commit_i) begin
         active_d = shadow_q;
         cnt_d    = '0;
         done_d   = 1'b0;
      end else if (clr_i) begin
         cnt_d  = '0;
         done_d = 1'b0;
      end else if (!counting) begin
         cnt_d = '0;
      end else if (run_i) begin
         if (cnt_q == period) begin
            cnt_d  = '0;
            tick_d = 1'b1;
            if (mode == MODE_ONESHOT) begin
               done_d = 1'b1;
            end
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow_q <= '0;
         active_q <= '0;
         cnt_q    <= '0;
         done_q   <= 1'b0;
         tick_q   <= 1'b0;
      end else begin
         shadow_q <= shadow_d;
         active_q <= active_d;
         cnt_q    <= cnt_d;
         done_q   <= done_d;
         tick_q   <= tick_d;
      end
   end

   assign ser_o  = shadow_q[0];
   assign tick_o = tick_q;

endmodule

// File: rtl/retospect_clockgen.sv
// Decay-clock generator top: commit detection on the falling config_en edge,
// scan-chain wiring through all channels and clockbus assembly.
module retospect_clockgen
   import retospect_clockgen_pkg::*;
#(
   parameter int N_CH  = 6,
   parameter int CNT_W = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            config_en,
   input  logic            bs_in,
   output logic            bs_out,
   input  logic            sync_clr,
   input  logic            run,
   output logic [N_CH+1:0] clockbus
);

   logic            cfg_q, cfg_d;
   logic            commit;
   logic [N_CH:0]   chain;
   logic [N_CH-1:0] tick;

   assign cfg_d  = config_en;
   assign commit = cfg_q & ~config_en;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cfg_q <= 1'b0;
      end else begin
         cfg_q <= cfg_d;
      end
   end

   // Serial data enters channel 0 and exits from the LSB of the last channel.
   assign chain[0] = bs_in;

   for (genvar k = 0; k < N_CH; k++) begin : g_ch
      retospect_clockgen_ch #(
         .CNT_W(CNT_W)
      ) u_ch (
         .clk       (clk),
         .rst_n     (rst_n),
         .shift_en_i(config_en),
         .ser_i     (chain[k]),
         .ser_o     (chain[k+1]),
         .commit_i  (commit),
         .clr_i     (sync_clr),
         .run_i     (run),
         .tick_o    (tick[k])
      );
   end

   assign bs_out   = chain[N_CH];
   assign clockbus = {tick, run, 1'b0};

endmodule

// File: tb/tb_retospect_clockgen.sv
// Directed self-checking bench for the decay-clock generator: scan programming,
// periodic/one-shot pulses, run gating, readback and async reset behaviour.
module tb_retospect_clockgen;

   localparam int N_CH      = 6;
   localparam int CNT_W     = 8;
   localparam int CFG_W     = CNT_W + 2;
   localparam int CHAIN_LEN = N_CH * CFG_W;

   logic            clk;
   logic            rst_n;
   logic            config_en;
   logic            bs_in;
   logic            bs_out;
   logic            sync_clr;
   logic            run;
   logic [N_CH+1:0] clockbus;

   int checkCount;
   int failCount;

   retospect_clockgen #(
      .N_CH (N_CH),
      .CNT_W(CNT_W)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .config_en(config_en),
      .bs_in    (bs_in),
      .bs_out   (bs_out),
      .sync_clr (sync_clr),
      .run      (run),
      .clockbus (clockbus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic cfgEn, input logic bsIn, input logic syncClr, input logic runIn);
      config_en = cfgEn;
      bs_in     = bsIn;
      sync_clr  = syncClr;
      run       = runIn;
      @(posedge clk);
      #1;
   endtask

   // Channel k word lands at chain bits [(N_CH-1-k)*CFG_W +: CFG_W]; bit 0 is shifted first.
   function automatic logic [CHAIN_LEN-1:0] buildChain(input logic [N_CH-1:0][CFG_W-1:0] words);
      logic [CHAIN_LEN-1:0] c;
      c = '0;
      for (int k = 0; k < N_CH; k++) begin
         c[(N_CH-1-k)*CFG_W +: CFG_W] = words[k];
      end
      return c;
   endfunction

   task automatic shiftAndCommit(input logic [CHAIN_LEN-1:0] chainBits, input logic runIn);
      for (int i = 0; i < CHAIN_LEN; i++) begin
         applyStimulus(1'b1, chainBits[i], 1'b0, runIn);
      end
      applyStimulus(1'b0, 1'b0, 1'b0, runIn);
   endtask

   logic [N_CH-1:0][CFG_W-1:0] words;
   logic [CHAIN_LEN-1:0]       pat;
   logic [7:0]                 a5;
   logic [5:0]                 runSeq, expCh0, expCh2;

   initial begin
      checkCount = 0;
      failCount  = 0;
      rst_n      = 1'b0;
      config_en  = 1'b0;
      bs_in      = 1'b0;
      sync_clr   = 1'b0;
      run        = 1'b1;

      // Reset state
      #7;
      checkOutput("reset_clockbus", 32'(clockbus), 32'(8'b0000_0010));
      checkOutput("reset_bs_out", 32'(bs_out), 32'd0);
      rst_n = 1'b1;

      // All channels OFF, clockbus[1] follows run
      words = '0;
      shiftAndCommit(buildChain(words), 1'b1);
      for (int i = 0; i < 100; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b0, (i % 3) != 0);
         checkOutput("off_bus", 32'(clockbus), 32'({6'b0, run, 1'b0}));
      end

      // ch0 PERIODIC P=3: pulses at 4, 8, 12 after commit
      words    = '0;
      words[0] = {2'b01, 8'd3};
      shiftAndCommit(buildChain(words), 1'b1);
      checkOutput("per_after_commit", 32'(clockbus[2]), 32'd0);
      for (int n = 1; n <= 12; n++) begin
         applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
         checkOutput("per_p3", 32'(clockbus[2]), 32'((n % 4) == 0));
      end

      // ch1 ONESHOT P=5: single pulse at 6, silent for 50, then again after sync_clr
      words    = '0;
      words[1] = {2'b10, 8'd5};
      shiftAndCommit(buildChain(words), 1'b1);
      for (int n = 1; n <= 56; n++) begin
         applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
         checkOutput("oneshot", 32'(clockbus[3]), 32'(n == 6));
      end
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
      checkOutput("oneshot_clr", 32'(clockbus[3]), 32'd0);
      for (int n = 1; n <= 8; n++) begin
         applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
         checkOutput("oneshot_rearm", 32'(clockbus[3]), 32'(n == 6));
      end

      // ch2 P=0 follows run with one cycle lag; ch0 P=3 resumes its held count
      words    = '0;
      words[0] = {2'b01, 8'd3};
      words[2] = {2'b01, 8'd0};
      shiftAndCommit(buildChain(words), 1'b1);
      runSeq = 6'b110011;
      expCh0 = 6'b100000;
      expCh2 = 6'b110011;
      for (int i = 0; i < 6; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b0, runSeq[i]);
         checkOutput("run_ch2", 32'(clockbus[4]), 32'(expCh2[i]));
         checkOutput("run_ch0", 32'(clockbus[2]), 32'(expCh0[i]));
         checkOutput("run_bus1", 32'(clockbus[1]), 32'(runSeq[i]));
      end

      // Readback: ticks drop after config_en rises, bs_out replays shifted bits in order
      checkOutput("pre_shift_tick", 32'(clockbus[4]), 32'd1);
      a5 = 8'hA5;
      for (int i = 0; i < CHAIN_LEN; i++) begin
         pat[i] = a5[i % 8];
      end
      for (int i = 0; i < CHAIN_LEN; i++) begin
         applyStimulus(1'b1, pat[i], 1'b0, 1'b1);
         checkOutput("shift_ticks_off", 32'(clockbus[7:2]), 32'd0);
      end
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < CHAIN_LEN; i++) begin
         checkOutput("readback", 32'(bs_out), 32'(pat[i]));
         applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
      end

      // Reset mid-count
      words    = '0;
      words[2] = {2'b01, 8'd0};
      shiftAndCommit(buildChain(words), 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput("pre_reset_tick", 32'(clockbus[4]), 32'd1);
      #3 rst_n = 1'b0;
      #1;
      checkOutput("reset_count_bus", 32'(clockbus), 32'(8'b0000_0010));
      #2 rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
         checkOutput("post_reset_count", 32'(clockbus[7:2]), 32'd0);
      end

      // Reset mid-shift: no partial commit afterwards
      words    = '0;
      words[5] = {2'b01, 8'd0};
      words[4] = {2'b01, 8'd0};
      pat      = buildChain(words);
      for (int i = 0; i < 20; i++) begin
         applyStimulus(1'b1, pat[i], 1'b0, 1'b1);
      end
      #3 rst_n = 1'b0;
      config_en = 1'b0;
      #1;
      checkOutput("reset_shift_bus", 32'(clockbus), 32'(8'b0000_0010));
      checkOutput("reset_shift_bs", 32'(bs_out), 32'd0);
      #2 rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
         checkOutput("post_reset_shift", 32'({clockbus[7:2], bs_out}), 32'd0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end

endmodule
